// File: rtl/dispatch_queue_pkg.sv
// Shared constants for the dispatch queue: channel indices, default sizing,
// and a width helper used by the interface and the top.
package dispatch_queue_pkg;

  localparam int CH_ALU = 0;
  localparam int CH_MUL = 1;
  localparam int CH_BR  = 2;
  localparam int CH_MEM = 3;

  localparam int DQ_DEPTH     = 4;
  localparam int DQ_NUM_CH    = 4;
  localparam int DQ_NUM_CDB   = 3;
  localparam int DQ_DATA_W    = 32;
  localparam int DQ_ROB_IDX_W = 5;
  localparam int DQ_PAYLOAD_W = 128;

  // Index width that never collapses to zero bits for a single-element range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Bus bundle between decode/rename, the CDB and the reservation stations.
// master = the surrounding pipeline, slave = the dispatch queue.
interface dispatch_queue_if
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH     = DQ_DEPTH,
  parameter int NUM_CH    = DQ_NUM_CH,
  parameter int NUM_CDB   = DQ_NUM_CDB,
  parameter int DATA_W    = DQ_DATA_W,
  parameter int ROB_IDX_W = DQ_ROB_IDX_W,
  parameter int PAYLOAD_W = DQ_PAYLOAD_W
);
  localparam int CLS_W = idx_w(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                         in_valid;
  logic                         in_ready;
  logic [CLS_W-1:0]             in_class;
  logic [ROB_IDX_W-1:0]         in_rs1_tag;
  logic [ROB_IDX_W-1:0]         in_rs2_tag;
  logic                         in_rs1_rdy;
  logic                         in_rs2_rdy;
  logic [DATA_W-1:0]            in_rs1_data;
  logic [DATA_W-1:0]            in_rs2_data;
  logic [PAYLOAD_W-1:0]         in_payload;

  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0]    cdb_data;

  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH-1:0]            ch_valid;
  logic [DATA_W-1:0]            out_rs1_data;
  logic [DATA_W-1:0]            out_rs2_data;
  logic                         out_rs1_rdy;
  logic                         out_rs2_rdy;
  logic [PAYLOAD_W-1:0]         out_payload;
  logic [CNT_W-1:0]             occupancy;

  modport master (
    output in_valid, in_class, in_rs1_tag, in_rs2_tag, in_rs1_rdy, in_rs2_rdy,
           in_rs1_data, in_rs2_data, in_payload,
           cdb_valid, cdb_tag, cdb_data, ch_ready,
    input  in_ready, ch_valid, out_rs1_data, out_rs2_data, out_rs1_rdy,
           out_rs2_rdy, out_payload, occupancy
  );

  modport slave (
    input  in_valid, in_class, in_rs1_tag, in_rs2_tag, in_rs1_rdy, in_rs2_rdy,
           in_rs1_data, in_rs2_data, in_payload,
           cdb_valid, cdb_tag, cdb_data, ch_ready,
    output in_ready, ch_valid, out_rs1_data, out_rs2_data, out_rs1_rdy,
           out_rs2_rdy, out_payload, occupancy
  );

endinterface

// File: rtl/dispatch_cdb_snoop.sv
// Compares one operand tag against every CDB port; the lowest matching
// port index supplies the data.
module dispatch_cdb_snoop #(
  parameter int NUM_CDB   = 3,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5
) (
  input  logic [ROB_IDX_W-1:0]         tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  logic [NUM_CDB-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CDB; gi++) begin : g_port
      assign match[gi] = cdb_valid[gi] && (cdb_tag[gi*ROB_IDX_W +: ROB_IDX_W] == tag);
    end
  endgenerate

  // Walk from the highest port down so the lowest matching index is the last writer.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (match[p]) begin
        hit  = 1'b1;
        data = cdb_data[p*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: buffered entries snoop the CDB every cycle and the
// head is steered to its reservation-station channel by op class.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH     = DQ_DEPTH,
  parameter int NUM_CH    = DQ_NUM_CH,
  parameter int NUM_CDB   = DQ_NUM_CDB,
  parameter int DATA_W    = DQ_DATA_W,
  parameter int ROB_IDX_W = DQ_ROB_IDX_W,
  parameter int PAYLOAD_W = DQ_PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  dispatch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CLS_W = idx_w(NUM_CH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CLS_W-1:0]     cls_q      [DEPTH];
  logic [CLS_W-1:0]     cls_d      [DEPTH];
  logic [ROB_IDX_W-1:0] rs1_tag_q  [DEPTH];
  logic [ROB_IDX_W-1:0] rs1_tag_d  [DEPTH];
  logic [ROB_IDX_W-1:0] rs2_tag_q  [DEPTH];
  logic [ROB_IDX_W-1:0] rs2_tag_d  [DEPTH];
  logic                 rs1_rdy_q  [DEPTH];
  logic                 rs1_rdy_d  [DEPTH];
  logic                 rs2_rdy_q  [DEPTH];
  logic                 rs2_rdy_d  [DEPTH];
  logic [DATA_W-1:0]    rs1_data_q [DEPTH];
  logic [DATA_W-1:0]    rs1_data_d [DEPTH];
  logic [DATA_W-1:0]    rs2_data_q [DEPTH];
  logic [DATA_W-1:0]    rs2_data_d [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d  [DEPTH];

  logic [DEPTH-1:0]     e_rs1_hit;
  logic [DEPTH-1:0]     e_rs2_hit;
  logic [DATA_W-1:0]    e_rs1_data [DEPTH];
  logic [DATA_W-1:0]    e_rs2_data [DEPTH];
  logic                 in_rs1_hit, in_rs2_hit;
  logic [DATA_W-1:0]    in_rs1_cap, in_rs2_cap;

  logic                 in_ready_w;
  logic                 nonempty;
  logic                 offer;
  logic                 enq_fire;
  logic                 deq_fire;
  logic [CLS_W-1:0]     head_cls;
  logic [NUM_CH-1:0]    ch_valid_w;

  genvar gi;

  // Capture at the enqueue port so a broadcast coinciding with enqueue is not lost.
  dispatch_cdb_snoop #(.NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_in_rs1 (
    .tag(bus.in_rs1_tag), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
    .cdb_data(bus.cdb_data), .hit(in_rs1_hit), .data(in_rs1_cap)
  );
  dispatch_cdb_snoop #(.NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_in_rs2 (
    .tag(bus.in_rs2_tag), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
    .cdb_data(bus.cdb_data), .hit(in_rs2_hit), .data(in_rs2_cap)
  );

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      dispatch_cdb_snoop #(.NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_rs1 (
        .tag(rs1_tag_q[gi]), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
        .cdb_data(bus.cdb_data), .hit(e_rs1_hit[gi]), .data(e_rs1_data[gi])
      );
      dispatch_cdb_snoop #(.NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .ROB_IDX_W(ROB_IDX_W)) u_rs2 (
        .tag(rs2_tag_q[gi]), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag),
        .cdb_data(bus.cdb_data), .hit(e_rs2_hit[gi]), .data(e_rs2_data[gi])
      );
    end

    for (gi = 0; gi < NUM_CH; gi++) begin : g_steer
      assign ch_valid_w[gi] = offer && (head_cls == CLS_W'(gi));
    end
  endgenerate

  assign nonempty   = (count_q != '0);
  assign offer      = nonempty && !flush;
  assign head_cls   = cls_q[head_q];
  assign in_ready_w = (count_q < CNT_W'(DEPTH)) && !flush;
  assign enq_fire   = bus.in_valid && in_ready_w;
  assign deq_fire   = |(ch_valid_w & bus.ch_ready);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      if (enq_fire && !deq_fire) count_d = count_q + CNT_W'(1);
      if (!enq_fire && deq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  // Dead slots also snoop; their contents are rewritten on enqueue anyway.
  always_comb begin
    cls_d      = cls_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_tag_d  = rs2_tag_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    payload_d  = payload_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rs1_rdy_q[i] && e_rs1_hit[i]) begin
        rs1_rdy_d[i]  = 1'b1;
        rs1_data_d[i] = e_rs1_data[i];
      end
      if (!rs2_rdy_q[i] && e_rs2_hit[i]) begin
        rs2_rdy_d[i]  = 1'b1;
        rs2_data_d[i] = e_rs2_data[i];
      end
      if (enq_fire && (tail_q == PTR_W'(i))) begin
        cls_d[i]      = bus.in_class;
        rs1_tag_d[i]  = bus.in_rs1_tag;
        rs2_tag_d[i]  = bus.in_rs2_tag;
        rs1_rdy_d[i]  = bus.in_rs1_rdy || in_rs1_hit;
        rs2_rdy_d[i]  = bus.in_rs2_rdy || in_rs2_hit;
        rs1_data_d[i] = (!bus.in_rs1_rdy && in_rs1_hit) ? in_rs1_cap : bus.in_rs1_data;
        rs2_data_d[i] = (!bus.in_rs2_rdy && in_rs2_hit) ? in_rs2_cap : bus.in_rs2_data;
        payload_d[i]  = bus.in_payload;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is observable until count says so.
  always_ff @(posedge clk) begin
    cls_q      <= cls_d;
    rs1_tag_q  <= rs1_tag_d;
    rs2_tag_q  <= rs2_tag_d;
    rs1_rdy_q  <= rs1_rdy_d;
    rs2_rdy_q  <= rs2_rdy_d;
    rs1_data_q <= rs1_data_d;
    rs2_data_q <= rs2_data_d;
    payload_q  <= payload_d;
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.ch_valid     = ch_valid_w;
  assign bus.occupancy    = count_q;
  assign bus.out_rs1_data = nonempty ? rs1_data_q[head_q] : '0;
  assign bus.out_rs2_data = nonempty ? rs2_data_q[head_q] : '0;
  assign bus.out_rs1_rdy  = nonempty ? rs1_rdy_q[head_q]  : 1'b0;
  assign bus.out_rs2_rdy  = nonempty ? rs2_rdy_q[head_q]  : 1'b0;
  assign bus.out_payload  = nonempty ? payload_q[head_q]  : '0;

endmodule

// File: tb/tb_dispatch_queue.sv
// Randomized and directed bench for dispatch_queue against a queue-based
// reference model of the in-order buffer with CDB snooping.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int NUM_CH  = 4;
  localparam int NUM_CDB = 3;
  localparam int DW      = 32;
  localparam int TW      = 5;
  localparam int PW      = 128;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  dispatch_queue_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .NUM_CDB(NUM_CDB),
                      .DATA_W(DW), .ROB_IDX_W(TW), .PAYLOAD_W(PW)) dq ();

  dispatch_queue #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .NUM_CDB(NUM_CDB),
                   .DATA_W(DW), .ROB_IDX_W(TW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(dq)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]    cls;
    logic [TW-1:0] t1, t2;
    logic          r1, r2;
    logic [DW-1:0] d1, d2;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t mq[$];

  function automatic bit cdb_hit(input logic [TW-1:0] tag, input logic [NUM_CDB-1:0] v,
                                 input logic [NUM_CDB*TW-1:0] tags,
                                 input logic [NUM_CDB*DW-1:0] data, output logic [DW-1:0] d);
    d = '0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (v[p] && tags[p*TW +: TW] == tag) begin
        d = data[p*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_chv();
    if (mq.size() == 0 || flush) return '0;
    return NUM_CH'(1) << mq[0].cls;
  endfunction

  // Advance one clock and apply the queue model to the inputs seen at the edge.
  task automatic tick();
    ent_t ne, e;
    logic iv, fl, rs, enq, deq;
    logic [NUM_CH-1:0] chr;
    logic [NUM_CDB-1:0] cv;
    logic [NUM_CDB*TW-1:0] ct;
    logic [NUM_CDB*DW-1:0] cd;
    logic [DW-1:0] d;
    iv = dq.in_valid; fl = flush; rs = rst; chr = dq.ch_ready;
    cv = dq.cdb_valid; ct = dq.cdb_tag; cd = dq.cdb_data;
    ne.cls = dq.in_class; ne.t1 = dq.in_rs1_tag; ne.t2 = dq.in_rs2_tag;
    ne.r1 = dq.in_rs1_rdy; ne.r2 = dq.in_rs2_rdy;
    ne.d1 = dq.in_rs1_data; ne.d2 = dq.in_rs2_data; ne.pl = dq.in_payload;
    @(posedge clk);
    if (!rs || fl) begin
      mq.delete();
    end else begin
      enq = iv && (mq.size() < DEPTH);
      deq = (mq.size() > 0) && chr[mq[0].cls];
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (!e.r1 && cdb_hit(e.t1, cv, ct, cd, d)) begin e.r1 = 1'b1; e.d1 = d; end
        if (!e.r2 && cdb_hit(e.t2, cv, ct, cd, d)) begin e.r2 = 1'b1; e.d2 = d; end
        mq[i] = e;
      end
      if (deq) void'(mq.pop_front());
      if (enq) begin
        if (!ne.r1 && cdb_hit(ne.t1, cv, ct, cd, d)) begin ne.r1 = 1'b1; ne.d1 = d; end
        if (!ne.r2 && cdb_hit(ne.t2, cv, ct, cd, d)) begin ne.r2 = 1'b1; ne.d2 = d; end
        mq.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle();
    dq.in_valid = 1'b0; dq.in_class = '0; dq.in_rs1_tag = '0; dq.in_rs2_tag = '0;
    dq.in_rs1_rdy = 1'b1; dq.in_rs2_rdy = 1'b1; dq.in_rs1_data = '0; dq.in_rs2_data = '0;
    dq.in_payload = '0; dq.cdb_valid = '0; dq.cdb_tag = '0; dq.cdb_data = '0;
    dq.ch_ready = '0; flush = 1'b0;
  endtask

  task automatic set_in(input logic [1:0] cls, input logic [TW-1:0] t1, input logic r1,
                        input logic [DW-1:0] d1, input logic [TW-1:0] t2, input logic r2,
                        input logic [DW-1:0] d2, input logic [PW-1:0] pl);
    dq.in_class = cls; dq.in_rs1_tag = t1; dq.in_rs1_rdy = r1; dq.in_rs1_data = d1;
    dq.in_rs2_tag = t2; dq.in_rs2_rdy = r2; dq.in_rs2_data = d2; dq.in_payload = pl;
  endtask

  task automatic test_reset();
    idle();
    #12;
    checks++; if (dq.occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", dq.occupancy); end
    checks++; if (dq.ch_valid !== 4'b0) begin errors++; $display("FAIL reset_chv: got %b exp 0000", dq.ch_valid); end
    checks++; if ({dq.out_rs1_data, dq.out_rs2_data, dq.out_rs1_rdy, dq.out_rs2_rdy} !== '0) begin
      errors++; $display("FAIL reset_out: got %h/%h exp 0", dq.out_rs1_data, dq.out_rs2_data); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (dq.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", dq.in_ready); end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    idle();
    set_in(2'(CH_BR), 5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22, 128'h1234);
    dq.in_valid = 1'b1; tick(); dq.in_valid = 1'b0;
    checks++; if (dq.ch_valid !== 4'b0100) begin errors++; $display("FAIL basic_chv: got %b exp 0100", dq.ch_valid); end
    checks++; if (dq.out_rs1_data !== 32'h11) begin errors++; $display("FAIL basic_rs1: got %h exp 11", dq.out_rs1_data); end
    checks++; if (dq.out_rs2_data !== 32'h22) begin errors++; $display("FAIL basic_rs2: got %h exp 22", dq.out_rs2_data); end
    checks++; if (dq.occupancy !== 3'd1) begin errors++; $display("FAIL basic_occ: got %0d exp 1", dq.occupancy); end
    dq.ch_ready = 4'b0100; tick(); dq.ch_ready = '0;
    checks++; if (dq.occupancy !== 3'd0 || dq.ch_valid !== 4'b0) begin
      errors++; $display("FAIL basic_deq: got occ=%0d chv=%b exp 0/0000", dq.occupancy, dq.ch_valid); end
    $display("test_basic done");
  endtask

  task automatic test_fill_wrap();
    idle();
    for (int k = 0; k < DEPTH; k++) begin
      set_in(2'($urandom_range(0, 3)), 5'd0, 1'b1, 32'(k), 5'd0, 1'b1, 32'(k), 128'(100 + k));
      dq.in_valid = 1'b1; tick();
    end
    checks++; if (dq.occupancy !== 3'd4 || dq.in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full: got occ=%0d in_ready=%b exp 4/0", dq.occupancy, dq.in_ready); end
    set_in(2'd0, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'd999);
    dq.ch_ready = '1; tick(); dq.in_valid = 1'b0;
    checks++; if (dq.occupancy !== 3'd3) begin errors++; $display("FAIL fill_no_passthru: got %0d exp 3", dq.occupancy); end
    for (int k = 1; k < DEPTH; k++) begin
      checks++; if (dq.out_payload !== 128'(100 + k)) begin
        errors++; $display("FAIL fill_order: got %0d exp %0d", dq.out_payload, 100 + k); end
      tick();
    end
    dq.ch_ready = '0;
    for (int k = 0; k < 3; k++) begin
      set_in(2'(k), 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'(200 + k));
      dq.in_valid = 1'b1; tick();
    end
    dq.in_valid = 1'b0; dq.ch_ready = '1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (dq.out_payload !== 128'(200 + k) || dq.ch_valid !== exp_chv()) begin
        errors++; $display("FAIL refill_order: got pl=%0d chv=%b exp %0d/%b", dq.out_payload, dq.ch_valid, 200 + k, exp_chv()); end
      tick();
    end
    dq.ch_ready = '0;
    $display("test_fill_wrap done");
  endtask

  task automatic test_wakeup();
    idle();
    set_in(2'(CH_MUL), 5'd7, 1'b0, 32'h0, 5'd2, 1'b1, 32'h55, 128'h77);
    dq.in_valid = 1'b1; tick(); dq.in_valid = 1'b0;
    checks++; if (dq.out_rs1_rdy !== 1'b0) begin errors++; $display("FAIL wake_pre: got %b exp 0", dq.out_rs1_rdy); end
    dq.cdb_valid = 3'b010; dq.cdb_tag = {5'd0, 5'd7, 5'd0}; dq.cdb_data = {32'h0, 32'hDEAD, 32'h0};
    tick(); dq.cdb_valid = '0;
    checks++; if (dq.out_rs1_rdy !== 1'b1 || dq.out_rs1_data !== 32'hDEAD || dq.ch_valid !== 4'b0010) begin
      errors++; $display("FAIL wake_hit: got rdy=%b data=%h chv=%b exp 1/dead/0010", dq.out_rs1_rdy, dq.out_rs1_data, dq.ch_valid); end
    dq.cdb_valid = 3'b001; dq.cdb_tag = {5'd0, 5'd0, 5'd7}; dq.cdb_data = {32'h0, 32'h0, 32'hBEEF};
    tick(); dq.cdb_valid = '0;
    checks++; if (dq.out_rs1_data !== 32'hDEAD) begin errors++; $display("FAIL wake_no_overwrite: got %h exp dead", dq.out_rs1_data); end
    dq.ch_ready = '1; tick(); dq.ch_ready = '0;
    $display("test_wakeup done");
  endtask

  task automatic test_capture_priority();
    idle();
    set_in(2'(CH_ALU), 5'd1, 1'b1, 32'h9, 5'd3, 1'b0, 32'h0, 128'h5);
    dq.cdb_valid = 3'b101; dq.cdb_tag = {5'd3, 5'd4, 5'd3}; dq.cdb_data = {32'hB, 32'hC, 32'hA};
    dq.in_valid = 1'b1; tick(); idle();
    checks++; if (dq.out_rs2_rdy !== 1'b1 || dq.out_rs2_data !== 32'hA) begin
      errors++; $display("FAIL capture_prio: got rdy=%b data=%h exp 1/a", dq.out_rs2_rdy, dq.out_rs2_data); end
    dq.ch_ready = '1; tick(); dq.ch_ready = '0;
    $display("test_capture_priority done");
  endtask

  task automatic test_back_to_back();
    idle();
    set_in(2'd0, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'hA1);
    dq.in_valid = 1'b1; tick();
    set_in(2'd1, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'hB2);
    dq.ch_ready = '1; tick();
    checks++; if (dq.occupancy !== 3'd1 || dq.out_payload !== 128'hB2) begin
      errors++; $display("FAIL b2b_one: got occ=%0d pl=%h exp 1/b2", dq.occupancy, dq.out_payload); end
    dq.ch_ready = '0;
    for (int k = 0; k < 2; k++) begin
      set_in(2'd2, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'(16'hC0 + k)); tick();
    end
    set_in(2'd3, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'hD0);
    dq.ch_ready = '1; tick(); dq.in_valid = 1'b0;
    checks++; if (dq.occupancy !== 3'd3 || dq.out_payload !== 128'hC0) begin
      errors++; $display("FAIL b2b_depth_m1: got occ=%0d pl=%h exp 3/c0", dq.occupancy, dq.out_payload); end
    for (int k = 0; k < 3; k++) tick();
    dq.ch_ready = '0;
    checks++; if (dq.occupancy !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d exp 0", dq.occupancy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    idle();
    for (int k = 0; k < 3; k++) begin
      set_in(2'd1, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 128'(k)); dq.in_valid = 1'b1; tick();
    end
    flush = 1'b1; #1;
    checks++; if (dq.ch_valid !== 4'b0 || dq.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: got chv=%b in_ready=%b exp 0000/0", dq.ch_valid, dq.in_ready); end
    tick(); flush = 1'b0; dq.in_valid = 1'b0;
    checks++; if (dq.occupancy !== 3'd0 || dq.ch_valid !== 4'b0) begin
      errors++; $display("FAIL flush_after: got occ=%0d chv=%b exp 0/0000", dq.occupancy, dq.ch_valid); end
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    idle();
    for (int k = 0; k < 2; k++) begin
      set_in(2'd3, 5'd0, 1'b1, 32'hF, 5'd0, 1'b1, 32'hF, 128'(k + 1)); dq.in_valid = 1'b1; tick();
    end
    dq.in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++; if (dq.occupancy !== 3'd0 || dq.ch_valid !== 4'b0 || dq.out_payload !== '0) begin
      errors++; $display("FAIL async_reset: got occ=%0d chv=%b exp 0/0000", dq.occupancy, dq.ch_valid); end
    mq.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dq.in_ready !== 1'b1 || dq.occupancy !== 3'd0) begin
      errors++; $display("FAIL async_release: got in_ready=%b occ=%0d exp 1/0", dq.in_ready, dq.occupancy); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e2;
    logic r1, r2;
    logic [PW-1:0] epl;
    idle();
    for (int n = 0; n < 400; n++) begin
      set_in(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom});
      dq.in_valid = ($urandom_range(0, 3) != 0);
      dq.cdb_valid = 3'($urandom);
      for (int p = 0; p < NUM_CDB; p++) begin
        dq.cdb_tag[p*TW +: TW] = 5'($urandom_range(0, 7));
        dq.cdb_data[p*DW +: DW] = $urandom;
      end
      dq.ch_ready = 4'($urandom);
      flush = ($urandom_range(0, 31) == 0);
      #1;
      checks++; if (dq.occupancy !== 3'(mq.size())) begin
        errors++; $display("FAIL rand_occ: got %0d exp %0d", dq.occupancy, mq.size()); end
      checks++; if (dq.ch_valid !== exp_chv()) begin
        errors++; $display("FAIL rand_chv: got %b exp %b", dq.ch_valid, exp_chv()); end
      checks++; if (dq.in_ready !== ((mq.size() < DEPTH) && !flush)) begin
        errors++; $display("FAIL rand_in_ready: got %b exp %b", dq.in_ready, (mq.size() < DEPTH) && !flush); end
      if (mq.size() > 0) begin
        r1 = mq[0].r1; e1 = mq[0].d1; r2 = mq[0].r2; e2 = mq[0].d2; epl = mq[0].pl;
      end else begin
        r1 = 1'b0; e1 = '0; r2 = 1'b0; e2 = '0; epl = '0;
      end
      checks++; if ({dq.out_rs1_rdy, dq.out_rs2_rdy} !== {r1, r2}) begin
        errors++; $display("FAIL rand_rdy: got %b%b exp %b%b", dq.out_rs1_rdy, dq.out_rs2_rdy, r1, r2); end
      checks++; if (r1 && dq.out_rs1_data !== e1) begin
        errors++; $display("FAIL rand_rs1: got %h exp %h", dq.out_rs1_data, e1); end
      checks++; if (r2 && dq.out_rs2_data !== e2) begin
        errors++; $display("FAIL rand_rs2: got %h exp %h", dq.out_rs2_data, e2); end
      checks++; if (dq.out_payload !== epl) begin
        errors++; $display("FAIL rand_payload: got %h exp %h", dq.out_payload, epl); end
      tick();
    end
    idle();
    $display("test_random done");
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill_wrap();
    test_wakeup();
    test_capture_priority();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
